// File: rtl/conditioner_scheduler_pkg.sv
// Shared constants and helpers for the time-multiplexed input conditioner.
package conditioner_scheduler_pkg;

  localparam int DEFAULT_NCH      = 4;
  localparam int DEFAULT_WAITTIME = 3;
  localparam int DEFAULT_CNTW     = 3;

  // Slot pointer width: a single channel still needs a one-bit pointer.
  function automatic int slot_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/conditioner_scheduler_sync2ff.sv
// Single-bit two-flop synchronizer for one asynchronous board input.
module conditioner_scheduler_sync2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its source, giving a true two-stage chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/conditioner_scheduler.sv
// Round-robin debouncer: per-channel synchronizers feed one shared
// compare/count/accept datapath that visits one channel per enabled cycle.
module conditioner_scheduler
  import conditioner_scheduler_pkg::*;
#(
  parameter int NCH      = DEFAULT_NCH,
  parameter int WAITTIME = DEFAULT_WAITTIME,
  parameter int CNTW     = DEFAULT_CNTW,
  parameter int SLOTW    = slot_width(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NCH-1:0]   noisysignal,
  output logic [NCH-1:0]   conditioned,
  output logic [NCH-1:0]   positiveedge,
  output logic [NCH-1:0]   negativeedge,
  output logic [SLOTW-1:0] slot
);

  localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(WAITTIME - 1);
  localparam logic [SLOTW-1:0] SLOT_LAST = SLOTW'(NCH - 1);

  logic [NCH-1:0]  sync1;
  logic [CNTW-1:0] cnt [NCH];
  logic            mismatch;
  logic            at_limit;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    conditioner_scheduler_sync2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (noisysignal[i]),
      .q     (sync1[i])
    );
  end

  // Shared evaluation datapath: only the channel under the slot pointer is seen.
  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    mismatch = (sync1[slot] != conditioned[slot]);
    at_limit = (cnt[slot] == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot         <= '0;
      conditioned  <= '0;
      positiveedge <= '0;
      negativeedge <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared by reset like any other state.
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      positiveedge <= '0;
      negativeedge <= '0;
      if (enable) begin
        slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        if (!mismatch) begin
          cnt[slot] <= '0;
        end else if (at_limit) begin
          cnt[slot]         <= '0;
          conditioned[slot] <= sync1[slot];
          if (sync1[slot]) positiveedge[slot] <= 1'b1;
          else             negativeedge[slot] <= 1'b1;
        end else begin
          cnt[slot] <= cnt[slot] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conditioner_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the debouncer.
module tb_conditioner_scheduler;

  localparam int NCH      = 4;
  localparam int WAITTIME = 3;
  localparam int CNTW     = 3;
  localparam int SLOTW    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [NCH-1:0]   noisysignal = '0;
  logic [NCH-1:0]   conditioned;
  logic [NCH-1:0]   positiveedge;
  logic [NCH-1:0]   negativeedge;
  logic [SLOTW-1:0] slot;

  int checks = 0;
  int errors = 0;

  conditioner_scheduler #(
    .NCH(NCH), .WAITTIME(WAITTIME), .CNTW(CNTW), .SLOTW(SLOTW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .noisysignal  (noisysignal),
    .conditioned  (conditioned),
    .positiveedge (positiveedge),
    .negativeedge (negativeedge),
    .slot         (slot)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // Reference model: pin history as a two-entry pipeline, visit counts as ints.
  bit [NCH-1:0] m_s0, m_s1, m_cond, m_pos, m_neg;
  int           m_visits [NCH];
  int           m_slot;

  function automatic void model_step(input bit rst, input bit en, input bit [NCH-1:0] ns);
    if (rst) begin
      m_s0 = '0; m_s1 = '0; m_cond = '0; m_pos = '0; m_neg = '0; m_slot = 0;
      for (int i = 0; i < NCH; i++) m_visits[i] = 0;
    end else begin
      m_pos = '0;
      m_neg = '0;
      if (en) begin
        int s = m_slot;
        if (m_s1[s] != m_cond[s]) begin
          m_visits[s] = m_visits[s] + 1;
          if (m_visits[s] == WAITTIME) begin
            m_visits[s] = 0;
            m_cond[s]   = m_s1[s];
            if (m_s1[s]) m_pos[s] = 1'b1;
            else         m_neg[s] = 1'b1;
          end
        end else begin
          m_visits[s] = 0;
        end
        m_slot = (m_slot + 1) % NCH;
      end
      m_s1 = m_s0;
      m_s0 = ns;
    end
  endfunction

  // Drive one cycle's inputs, advance the model at the edge, sample #1 later.
  task automatic tick(input bit rst, input bit en, input bit [NCH-1:0] ns);
    reset       = rst;
    enable      = en;
    noisysignal = ns;
    @(posedge clk);
    model_step(rst, en, ns);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, '1);
    checks += 4;
    if (conditioned !== '0) begin errors++; $display("FAIL reset_conditioned got %b exp 0", conditioned); end
    if (positiveedge !== '0) begin errors++; $display("FAIL reset_posedge got %b exp 0", positiveedge); end
    if (negativeedge !== '0) begin errors++; $display("FAIL reset_negedge got %b exp 0", negativeedge); end
    if (slot !== '0) begin errors++; $display("FAIL reset_slot got %0d exp 0", slot); end
    tick(1'b1, 1'b0, '0);
  endtask

  task automatic test_slot_walk();
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b1, '0);
      checks++;
      if (slot !== SLOTW'((k + 1) % NCH) || conditioned !== '0 ||
          positiveedge !== '0 || negativeedge !== '0) begin
        errors++;
        $display("FAIL slot_walk k=%0d slot %0d exp %0d cond %b pos %b neg %b exp all 0",
                 k, slot, (k + 1) % NCH, conditioned, positiveedge, negativeedge);
      end
    end
  endtask

  task automatic test_step();
    int rise_at = 0, pulse_at = 0, pulses = 0, stray = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 4'b0001);
      checks++;
      if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pos, m_neg} || slot !== SLOTW'(m_slot)) begin
        errors++;
        $display("FAIL step_model k=%0d got c%b p%b n%b s%0d exp c%b p%b n%b s%0d",
                 k, conditioned, positiveedge, negativeedge, slot, m_cond, m_pos, m_neg, m_slot);
      end
      if (conditioned[0] && rise_at == 0) rise_at = k;
      if (positiveedge[0]) begin pulses++; pulse_at = k; end
      if (conditioned[3:1] != 0 || positiveedge[3:1] != 0 || negativeedge != 0) stray++;
    end
    checks += 4;
    if (rise_at < 11 || rise_at > 14) begin errors++; $display("FAIL step_latency got %0d exp 11..14", rise_at); end
    if (pulses != 1) begin errors++; $display("FAIL step_pulse_count got %0d exp 1", pulses); end
    if (pulse_at != rise_at) begin errors++; $display("FAIL step_pulse_align got %0d exp %0d", pulse_at, rise_at); end
    if (stray != 0) begin errors++; $display("FAIL step_other_bits got %0d toggling cycles exp 0", stray); end
  endtask

  task automatic test_glitch();
    int bad = 0;
    for (int k = 0; k < 35; k++) begin
      tick(1'b0, 1'b1, (k < 5) ? 4'b0011 : 4'b0001);
      checks++;
      if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pos, m_neg} || slot !== SLOTW'(m_slot)) begin
        errors++;
        $display("FAIL glitch_model k=%0d got c%b p%b n%b exp c%b p%b n%b",
                 k, conditioned, positiveedge, negativeedge, m_cond, m_pos, m_neg);
      end
      if (conditioned !== 4'b0001 || positiveedge !== '0 || negativeedge !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL glitch_rejected got %0d disturbed cycles exp 0", bad); end
  endtask

  task automatic test_simultaneous();
    int cyc_q[$];
    int ch_q[$];
    tick(1'b1, 1'b0, '0);
    for (int k = 1; k <= 30; k++) begin
      tick(1'b0, 1'b1, '1);
      checks++;
      if (!$onehot0({positiveedge, negativeedge}) || negativeedge !== '0) begin
        errors++;
        $display("FAIL simul_onehot k=%0d pos %b neg %b", k, positiveedge, negativeedge);
      end
      for (int i = 0; i < NCH; i++)
        if (positiveedge[i]) begin cyc_q.push_back(k); ch_q.push_back(i); end
    end
    checks += 2;
    if (cyc_q.size() != NCH) begin
      errors++; $display("FAIL simul_pulse_count got %0d exp %0d", cyc_q.size(), NCH);
    end else begin
      for (int j = 1; j < NCH; j++) begin
        checks++;
        if (cyc_q[j] != cyc_q[j-1] + 1 || ch_q[j] != (ch_q[j-1] + 1) % NCH) begin
          errors++;
          $display("FAIL simul_order pulse %0d ch %0d at %0d after ch %0d at %0d",
                   j, ch_q[j], cyc_q[j], ch_q[j-1], cyc_q[j-1]);
        end
      end
    end
    if (conditioned !== '1) begin errors++; $display("FAIL simul_final got %b exp 1111", conditioned); end
  endtask

  task automatic test_enable_freeze();
    logic [SLOTW-1:0] held;
    int guard = 0, fired = 0;
    while (m_visits[2] != 1 && guard < 20) begin tick(1'b0, 1'b1, 4'b1011); guard++; end
    checks++;
    if (m_visits[2] != 1) begin errors++; $display("FAIL freeze_setup got visits %0d exp 1", m_visits[2]); end
    held = slot;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 4'b1011);
      checks++;
      if (slot !== held || positiveedge !== '0 || negativeedge !== '0 || conditioned !== 4'b1111) begin
        errors++;
        $display("FAIL freeze_hold k=%0d slot %0d exp %0d pos %b neg %b cond %b exp 1111",
                 k, slot, held, positiveedge, negativeedge, conditioned);
      end
    end
    for (int k = 0; k < 30 && fired == 0; k++) begin
      tick(1'b0, 1'b1, 4'b1011);
      checks++;
      if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pos, m_neg} || slot !== SLOTW'(m_slot)) begin
        errors++;
        $display("FAIL freeze_resume k=%0d got c%b p%b n%b exp c%b p%b n%b",
                 k, conditioned, positiveedge, negativeedge, m_cond, m_pos, m_neg);
      end
      if (negativeedge[2]) fired = 1;
    end
    checks++;
    if (fired == 0 || conditioned !== 4'b1011) begin
      errors++; $display("FAIL freeze_negedge fired %0d cond %b exp fired 1 cond 1011", fired, conditioned);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0, rise_at = 0;
    while (m_visits[3] != 2 && guard < 20) begin tick(1'b0, 1'b1, 4'b0011); guard++; end
    checks++;
    if (m_visits[3] != 2) begin errors++; $display("FAIL rstmid_setup got visits %0d exp 2", m_visits[3]); end
    tick(1'b1, 1'b1, 4'b0011);
    checks++;
    if (conditioned !== '0 || positiveedge !== '0 || negativeedge !== '0 || slot !== '0) begin
      errors++;
      $display("FAIL rstmid_clear cond %b pos %b neg %b slot %0d exp all 0",
               conditioned, positiveedge, negativeedge, slot);
    end
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 4'b1000);
      checks++;
      if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pos, m_neg} || slot !== SLOTW'(m_slot)) begin
        errors++;
        $display("FAIL rstmid_model k=%0d got c%b p%b n%b exp c%b p%b n%b",
                 k, conditioned, positiveedge, negativeedge, m_cond, m_pos, m_neg);
      end
      if (conditioned[3] && rise_at == 0) rise_at = k;
    end
    checks++;
    if (rise_at != 12) begin errors++; $display("FAIL rstmid_restart got %0d exp 12", rise_at); end
  endtask

  task automatic test_random();
    bit [NCH-1:0] ns = '0;
    bit rst, en;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 15) == 0) ns[i] = ~ns[i];
      tick(rst, en, ns);
      checks++;
      if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pos, m_neg} || slot !== SLOTW'(m_slot) ||
          !$onehot0({positiveedge, negativeedge})) begin
        errors++;
        $display("FAIL random k=%0d got c%b p%b n%b s%0d exp c%b p%b n%b s%0d",
                 k, conditioned, positiveedge, negativeedge, slot, m_cond, m_pos, m_neg, m_slot);
      end
    end
  endtask

  initial begin
    model_step(1'b1, 1'b0, '0);
    test_reset();
    test_slot_walk();
    test_step();
    test_glitch();
    test_simultaneous();
    test_enable_freeze();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
